// File: rtl/gcd_host.sv
// gcd_host: request/response front end for an external multi-cycle GCD engine.
// Accepts one operand pair at a time, short-circuits zero operands, launches the
// engine, waits for its result with a bounded timeout, and holds the response
// until the downstream consumer takes it.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   req_valid/req_ready         operand handshake, req_a/req_b operands
//   eng_start, eng_a, eng_b     one-cycle launch pulse and operands to engine
//   eng_done, eng_result        engine completion and GCD value (used in WAIT)
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_timeout       GCD result (0 on timeout), timeout flag
//   busy                        high whenever a transaction is in flight
module gcd_host #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_timeout,
  output logic             busy
);

  localparam int unsigned CNT_W = 16;
  // Last counter value before abort: the TIMEOUT-th WAIT cycle sees cnt == TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   eng_a_d, eng_b_d, rsp_data_d;
  logic               rsp_timeout_d;
  logic               req_ready_d, eng_start_d, rsp_valid_d, busy_d;

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      eng_a       <= '0;
      eng_b       <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      req_ready   <= 1'b1;
      eng_start   <= 1'b0;
      rsp_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      eng_a       <= eng_a_d;
      eng_b       <= eng_b_d;
      rsp_data    <= rsp_data_d;
      rsp_timeout <= rsp_timeout_d;
      req_ready   <= req_ready_d;
      eng_start   <= eng_start_d;
      rsp_valid   <= rsp_valid_d;
      busy        <= busy_d;
    end
  end

  // Next state and next output values; flag outputs are decoded from the next
  // state so they line up with the state register.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    eng_a_d       = eng_a;
    eng_b_d       = eng_b;
    rsp_data_d    = rsp_data;
    rsp_timeout_d = rsp_timeout;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_a == '0 || req_b == '0) begin
            // gcd(0,x) = x and gcd(0,0) = 0, so OR gives the answer directly.
            state_d       = RESP;
            rsp_data_d    = req_a | req_b;
            rsp_timeout_d = 1'b0;
          end else begin
            state_d = LAUNCH;
            eng_a_d = req_a;
            eng_b_d = req_b;
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // A result arriving on the final cycle still wins over the abort.
        if (eng_done) begin
          state_d       = RESP;
          rsp_data_d    = eng_result;
          rsp_timeout_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = RESP;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    eng_start_d = (state_d == LAUNCH);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

endmodule

// File: tb/tb_gcd_host.sv
// Directed bench for gcd_host with an expected-response scoreboard queue.
module tb_gcd_host;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned TIMEOUT = 10;

  logic             clk, rst;
  logic             req_valid, req_ready;
  logic [WIDTH-1:0] req_a, req_b;
  logic             eng_start;
  logic [WIDTH-1:0] eng_a, eng_b;
  logic             eng_done;
  logic [WIDTH-1:0] eng_result;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_timeout;
  logic             busy;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             timeout;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;

  gcd_host #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (eng_start) start_cnt <= start_cnt + 1;

  function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x, y, t;
    x = a;
    y = b;
    for (int i = 0; i < 64; i++) begin
      if (y == '0) break;
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request and push what the response must be.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic to);
    exp_t e;
    int n;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("req_ready_wait", req_ready, 1);
    if (to) e = '{data: '0, timeout: 1'b1};
    else if (a == '0 || b == '0) e = '{data: a | b, timeout: 1'b0};
    else e = '{data: ref_gcd(a, b), timeout: 1'b0};
    exp_q.push_back(e);
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic chk_rsp(input string tag);
    exp_t e;
    chk({tag, "_valid"}, rsp_valid, 1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, rsp_data, e.data);
      chk({tag, "_timeout"}, rsp_timeout, e.timeout);
    end
  endtask

  initial begin
    int s0, n;
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
    eng_done = 1'b0; eng_result = '0; rsp_ready = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_a", eng_a, 0);
    chk("rst_eng_b", eng_b, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    tick();
    chk("idle_req_ready", req_ready, 1);

    // Engine path: (48,18), result after 4 WAIT cycles.
    s0 = start_cnt;
    send(8'd48, 8'd18, 1'b0);
    chk("launch_start", eng_start, 1);
    chk("launch_eng_a", eng_a, 48);
    chk("launch_eng_b", eng_b, 18);
    chk("launch_req_ready", req_ready, 0);
    chk("launch_busy", busy, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wait_no_rsp", rsp_valid, 0);
      chk("wait_no_start", eng_start, 0);
      tick();
    end
    eng_done = 1'b1; eng_result = 8'd6;
    tick();
    eng_done = 1'b0;
    chk_rsp("eng48_18");
    chk("eng48_18_starts", start_cnt - s0, 1);
    chk("eng48_18_hold_a", eng_a, 48);
    tick();
    chk("eng48_18_idle_ready", req_ready, 1);
    chk("eng48_18_idle_valid", rsp_valid, 0);

    // Bypass (0,35) and (0,0): response one cycle after accept, no launch.
    s0 = start_cnt;
    send(8'd0, 8'd35, 1'b0);
    chk("byp35_no_start", eng_start, 0);
    chk_rsp("byp35");
    tick();
    chk("byp35_idle_ready", req_ready, 1);
    send(8'd0, 8'd0, 1'b0);
    chk_rsp("byp00");
    tick();
    chk("byp_starts", start_cnt - s0, 0);

    // Engine never answers: abort after TIMEOUT WAIT cycles.
    send(8'd200, 8'd3, 1'b1);
    tick();
    n = 0;
    while (!rsp_valid && n < 50) begin
      if (busy && !eng_start) n++;
      tick();
    end
    chk("to_wait_cycles", n, TIMEOUT);
    chk_rsp("timeout");
    tick();
    chk("to_idle_ready", req_ready, 1);

    // eng_done on the final WAIT cycle beats the abort.
    send(8'd12, 8'd8, 1'b0);
    tick();
    repeat (TIMEOUT - 1) tick();
    chk("edge_still_wait", rsp_valid, 0);
    eng_done = 1'b1; eng_result = 8'd4;
    tick();
    eng_done = 1'b0;
    chk_rsp("edge_done");
    tick();

    // Stalled responder: response held, new requests refused.
    rsp_ready = 1'b0;
    send(8'd0, 8'd77, 1'b0);
    chk_rsp("stall");
    req_a = 8'd1; req_b = 8'd2; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, 77);
      chk("stall_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("stall_idle_ready", req_ready, 1);
    chk("stall_idle_busy", busy, 0);
    chk("stall_sb_empty", exp_q.size(), 0);

    // Reset during WAIT, late eng_done ignored, then a clean transaction.
    send(8'd30, 8'd12, 1'b0);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_req_ready", req_ready, 1);
    chk("arst_eng_a", eng_a, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    void'(exp_q.pop_front());
    @(negedge clk) rst = 1'b1;
    eng_done = 1'b1; eng_result = 8'd99;
    tick();
    tick();
    chk("late_done_valid", rsp_valid, 0);
    chk("late_done_busy", busy, 0);
    eng_done = 1'b0;
    send(8'd30, 8'd12, 1'b0);
    tick();
    eng_done = 1'b1; eng_result = 8'd6;
    tick();
    eng_done = 1'b0;
    chk_rsp("post_rst");
    tick();
    chk("post_rst_ready", req_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
